// File: rtl/fg_trapezoid_gen.sv
// Trapezoid/pulse waveform generator channel: period counter, shadowed configuration,
// one-shot/continuous run control and saturated signed output.
module fg_trapezoid_gen #(
  parameter int unsigned COUNTER_BITWIDTH  = 32,
  parameter int unsigned WAVEFORM_BITWIDTH = 16
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                clk_en_i,
  input  logic                                run_i,
  input  logic                                oneshot_i,
  input  logic [COUNTER_BITWIDTH-1:0]         period_i,
  input  logic [COUNTER_BITWIDTH-1:0]         on_time_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]        k_rise_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]        k_fall_i,
  input  logic [WAVEFORM_BITWIDTH-1:0]        amplitude_i,
  input  logic signed [WAVEFORM_BITWIDTH:0]   offset_i,
  input  logic                                invert_i,
  output logic signed [WAVEFORM_BITWIDTH:0]   out_o,
  output logic [1:0]                          phase_o,
  output logic                                period_start_o,
  output logic                                done_o
);

  localparam int unsigned CW = COUNTER_BITWIDTH;
  localparam int unsigned W  = WAVEFORM_BITWIDTH;
  localparam int unsigned OW = W + 1;
  localparam int unsigned SW = W + 3;
  localparam logic signed [SW-1:0] OUT_MAX = SW'((64'd1 << W) - 64'd1);
  localparam logic signed [SW-1:0] OUT_MIN = -OUT_MAX - SW'(1);

  typedef enum logic [1:0] {
    PH_ZERO = 2'd0,
    PH_RISE = 2'd1,
    PH_ON   = 2'd2,
    PH_FALL = 2'd3
  } phase_e;

  logic [CW-1:0]        c_q, c_d;
  logic [W-1:0]         val_q, val_d;
  phase_e               phase_q, phase_d;
  logic signed [OW-1:0] out_q, out_d;
  logic                 ps_q, ps_d;
  logic                 done_q, done_d;
  logic                 os_run_q, os_run_d;
  logic                 fin_q, fin_d;
  logic                 run_prev_q, run_prev_d;

  logic [CW-1:0]        period_s_q, period_s_d;
  logic [CW-1:0]        on_time_s_q, on_time_s_d;
  logic [W-1:0]         k_rise_s_q, k_rise_s_d;
  logic [W-1:0]         k_fall_s_q, k_fall_s_d;
  logic [W-1:0]         amp_s_q, amp_s_d;
  logic signed [OW-1:0] offset_s_q, offset_s_d;
  logic                 invert_s_q, invert_s_d;

  // Effective configuration for this tick: inputs at a period start, shadows otherwise
  logic [CW-1:0]        period_e, on_time_e;
  logic [W-1:0]         k_rise_e, k_fall_e, amp_e;
  logic signed [OW-1:0] offset_e;
  logic                 invert_e;
  logic                 active, run_rise;
  logic [W:0]           rise_sum;
  logic signed [SW-1:0] ramp, sum;

  always_comb begin
    c_d         = c_q;
    val_d       = val_q;
    phase_d     = phase_q;
    out_d       = out_q;
    ps_d        = 1'b0;
    done_d      = done_q;
    os_run_d    = os_run_q;
    fin_d       = fin_q;
    run_prev_d  = run_prev_q;
    period_s_d  = period_s_q;
    on_time_s_d = on_time_s_q;
    k_rise_s_d  = k_rise_s_q;
    k_fall_s_d  = k_fall_s_q;
    amp_s_d     = amp_s_q;
    offset_s_d  = offset_s_q;
    invert_s_d  = invert_s_q;
    period_e    = period_s_q;
    on_time_e   = on_time_s_q;
    k_rise_e    = k_rise_s_q;
    k_fall_e    = k_fall_s_q;
    amp_e       = amp_s_q;
    offset_e    = offset_s_q;
    invert_e    = invert_s_q;
    active      = 1'b0;
    run_rise    = 1'b0;
    rise_sum    = '0;
    ramp        = '0;
    sum         = '0;

    if (clk_en_i) begin
      run_prev_d = run_i;
      run_rise   = run_i & ~run_prev_q;
      fin_d      = 1'b0;

      if (c_q == '0) begin
        period_e    = period_i;
        on_time_e   = on_time_i;
        k_rise_e    = k_rise_i;
        k_fall_e    = k_fall_i;
        amp_e       = amplitude_i;
        offset_e    = offset_i;
        invert_e    = invert_i;
        period_s_d  = period_i;
        on_time_s_d = on_time_i;
        k_rise_s_d  = k_rise_i;
        k_fall_s_d  = k_fall_i;
        amp_s_d     = amplitude_i;
        offset_s_d  = offset_i;
        invert_s_d  = invert_i;
      end

      if (oneshot_i) active = run_i & (os_run_q | (run_rise & ~done_q));
      else           active = run_i;

      if (active) begin
        if (c_q == '0)                                 phase_d = PH_RISE;
        else if (c_q == on_time_e)                     phase_d = PH_FALL;
        else if (phase_q == PH_RISE && val_q == amp_e) phase_d = PH_ON;
        else if (phase_q == PH_FALL && val_q == '0)    phase_d = PH_ZERO;
        else                                           phase_d = phase_q;

        rise_sum = {1'b0, val_q} + {1'b0, k_rise_e};
        unique case (phase_d)
          PH_RISE: val_d = (k_rise_e == '0 || rise_sum >= {1'b0, amp_e}) ? amp_e : rise_sum[W-1:0];
          PH_ON:   val_d = amp_e;
          PH_FALL: val_d = (k_fall_e == '0 || val_q <= k_fall_e) ? '0 : val_q - k_fall_e;
          default: val_d = '0;
        endcase

        ps_d   = (c_q == '0);
        c_d    = (c_q == period_e) ? '0 : c_q + CW'(1);
        done_d = 1'b0;
        // One-shot ends after the last counter value; done follows on the next tick
        if (oneshot_i && c_q == period_e) begin
          os_run_d = 1'b0;
          fin_d    = 1'b1;
        end else begin
          os_run_d = oneshot_i;
        end
      end else begin
        c_d      = '0;
        val_d    = '0;
        phase_d  = PH_ZERO;
        os_run_d = 1'b0;
        done_d   = oneshot_i & run_i & (done_q | fin_q);
      end

      ramp = invert_e ? -$signed({3'b000, val_d}) : $signed({3'b000, val_d});
      sum  = SW'(offset_e) + ramp;
      if (sum > OUT_MAX)      out_d = OW'(OUT_MAX);
      else if (sum < OUT_MIN) out_d = OW'(OUT_MIN);
      else                    out_d = OW'(sum);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      c_q         <= '0;
      val_q       <= '0;
      phase_q     <= PH_ZERO;
      out_q       <= '0;
      ps_q        <= 1'b0;
      done_q      <= 1'b0;
      os_run_q    <= 1'b0;
      fin_q       <= 1'b0;
      run_prev_q  <= 1'b0;
      period_s_q  <= '0;
      on_time_s_q <= '0;
      k_rise_s_q  <= '0;
      k_fall_s_q  <= '0;
      amp_s_q     <= '0;
      offset_s_q  <= '0;
      invert_s_q  <= 1'b0;
    end else begin
      c_q         <= c_d;
      val_q       <= val_d;
      phase_q     <= phase_d;
      out_q       <= out_d;
      ps_q        <= ps_d;
      done_q      <= done_d;
      os_run_q    <= os_run_d;
      fin_q       <= fin_d;
      run_prev_q  <= run_prev_d;
      period_s_q  <= period_s_d;
      on_time_s_q <= on_time_s_d;
      k_rise_s_q  <= k_rise_s_d;
      k_fall_s_q  <= k_fall_s_d;
      amp_s_q     <= amp_s_d;
      offset_s_q  <= offset_s_d;
      invert_s_q  <= invert_s_d;
    end
  end

  assign out_o          = out_q;
  assign phase_o        = phase_q;
  assign period_start_o = ps_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_fg_trapezoid_gen.sv
// Directed bench for fg_trapezoid_gen with W=8, counter width 8.
module tb_fg_trapezoid_gen;

  logic              clk = 1'b0;
  logic              rstn, clk_en, run, oneshot, invert;
  logic [7:0]        period, on_time, k_rise, k_fall, amp;
  logic signed [8:0] offset;
  logic signed [8:0] out;
  logic [1:0]        phase;
  logic              pstart, done;

  int total = 0;
  int bad   = 0;

  int base_out[11] = '{40, 80, 100, 100, 100, 70, 40, 10, 0, 0, 40};
  int base_ph[11]  = '{1, 1, 1, 2, 2, 3, 3, 3, 3, 0, 1};

  always #5 clk = ~clk;

  fg_trapezoid_gen #(.COUNTER_BITWIDTH(8), .WAVEFORM_BITWIDTH(8)) dut (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(clk_en), .run_i(run), .oneshot_i(oneshot),
    .period_i(period), .on_time_i(on_time), .k_rise_i(k_rise), .k_fall_i(k_fall),
    .amplitude_i(amp), .offset_i(offset), .invert_i(invert),
    .out_o(out), .phase_o(phase), .period_start_o(pstart), .done_o(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat9(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  int offs[3] = '{-50, 200, -200};
  int invs[3] = '{1, 0, 1};
  int ph6[12] = '{1, 1, 1, 2, 1, 2, 2, 2, 1, 2, 2, 2};

  initial begin
    rstn = 1'b0; clk_en = 1'b1; run = 1'b0; oneshot = 1'b0; invert = 1'b0;
    period = 8'd9; on_time = 8'd5; k_rise = 8'd40; k_fall = 8'd30; amp = 8'd100; offset = '0;
    tick(); tick();
    chk("rst out", out, 0);
    chk("rst phase", phase, 0);
    chk("rst pstart", pstart, 0);
    chk("rst done", done, 0);
    rstn = 1'b1;
    tick();
    chk("idle out", out, 0);

    // continuous trapezoid
    run = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("cont out t%0d", i + 1), out, base_out[i]);
      chk($sformatf("cont phase t%0d", i + 1), phase, base_ph[i]);
      chk($sformatf("cont pstart t%0d", i + 1), pstart, (i == 0 || i == 10) ? 1 : 0);
    end
    run = 1'b0;
    tick();
    chk("stop out", out, 0);
    chk("stop phase", phase, 0);

    // square wave and amplitude change mid-period
    k_rise = 8'd0; k_fall = 8'd0; run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 2) amp = 8'd50;
      if (i < 5)       chk($sformatf("sq out t%0d", i + 1), out, 100);
      else if (i < 10) chk($sformatf("sq out t%0d", i + 1), out, 0);
      else             chk($sformatf("sq out t%0d", i + 1), out, 50);
    end
    run = 1'b0; amp = 8'd100; k_rise = 8'd40; k_fall = 8'd30;
    tick();

    // offset / inversion / saturation
    for (int k = 0; k < 3; k++) begin
      offset = 9'(offs[k]); invert = invs[k][0];
      tick();
      chk($sformatf("idle offset cfg%0d", k), out, sat9(offs[k]));
      run = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        chk($sformatf("offs cfg%0d t%0d", k, i + 1), out,
            sat9(offs[k] + (invs[k] != 0 ? -base_out[i] : base_out[i])));
      end
      run = 1'b0;
      tick();
    end
    offset = '0; invert = 1'b0;
    tick();
    chk("offset cleared", out, 0);

    // one-shot
    oneshot = 1'b1; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("os1 out t%0d", i + 1), out, base_out[i]);
      chk($sformatf("os1 done t%0d", i + 1), done, 0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("os1 end done %0d", i), done, 1);
      chk($sformatf("os1 end out %0d", i), out, 0);
      chk($sformatf("os1 end pstart %0d", i), pstart, 0);
    end
    run = 1'b0;
    tick();
    chk("os clear done", done, 0);
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("os2 out t%0d", i + 1), out, base_out[i]);
    end
    tick();
    chk("os2 done", done, 1);
    run = 1'b0; oneshot = 1'b0;
    tick();

    // half-rate clock enable
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clk_en = 1'b1;
      tick();
      chk($sformatf("en out t%0d", i + 1), out, base_out[i]);
      chk($sformatf("en pstart t%0d", i + 1), pstart, (i == 0) ? 1 : 0);
      clk_en = 1'b0;
      tick();
      chk($sformatf("dis out t%0d", i + 1), out, base_out[i]);
      chk($sformatf("dis phase t%0d", i + 1), phase, base_ph[i]);
      chk($sformatf("dis pstart t%0d", i + 1), pstart, 0);
    end
    clk_en = 1'b1; run = 1'b0;
    tick();

    // asynchronous reset mid-rise
    run = 1'b1;
    tick(); tick();
    chk("pre-rst out", out, 80);
    rstn = 1'b0;
    #1;
    chk("async rst out", out, 0);
    chk("async rst phase", phase, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("post-rst out", out, 40);
    chk("post-rst pstart", pstart, 1);
    tick();
    chk("post-rst out2", out, 80);
    run = 1'b0;
    tick();

    // on_time beyond period: never falls
    period = 8'd3;
    tick();
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("nofall out t%0d", i + 1), out, (i < 2) ? (i + 1) * 40 : 100);
      chk($sformatf("nofall phase t%0d", i + 1), phase, ph6[i]);
    end
    run = 1'b0;
    tick();

    // zero-length period
    period = 8'd0;
    tick();
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("p0 pstart t%0d", i + 1), pstart, 1);
      chk($sformatf("p0 out t%0d", i + 1), out, (i < 2) ? (i + 1) * 40 : 100);
    end
    run = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
